// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: one shared edge- or center-aligned time base drives N
// registered compare outputs; period, duty and mode are double-buffered until a period boundary.
//
// dir state | meaning
// UP        | center mode rising toward period_a (also the idle/edge-mode value)
// DOWN      | center mode falling toward the valley
module pwm_timer_multi #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic             update,
  input  logic             mode_in,
  input  logic [W-1:0]     period_in,
  input  logic [N*W-1:0]   duty_in,
  output logic [W-1:0]     cnt,
  output logic [N-1:0]     pwm_out,
  output logic             period_evt,
  output logic             upd_pending
);

  localparam logic [0:0] UP   = 1'b0;
  localparam logic [0:0] DOWN = 1'b1;

  logic [0:0]   dir;
  logic [0:0]   dir_nxt;
  logic         mode_a;
  logic [W-1:0] period_a;
  logic [W-1:0] duty_a [N];
  logic         boundary;
  logic         xfer;
  logic         do_xfer;
  logic         nxt_mode;
  logic [W-1:0] nxt_per;
  logic [W-1:0] cnt_nxt;
  logic [N-1:0] cmp;

  assign boundary = (period_a == '0) || ((cnt == '0) && (!mode_a || (dir == DOWN)));
  assign xfer     = boundary && (upd_pending || update);
  assign do_xfer  = load || (enable && xfer);

  // A boundary restarts the period using whichever mode/period is active after the edge.
  assign nxt_mode = xfer ? mode_in : mode_a;
  assign nxt_per  = xfer ? period_in : period_a;

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (boundary) begin
      dir_nxt = UP;
      if (!nxt_mode)
        cnt_nxt = nxt_per;
      else if (nxt_per != '0)
        cnt_nxt = W'(1);
      else
        cnt_nxt = '0;
    end else if (!mode_a) begin
      cnt_nxt = cnt - W'(1);
    end else if (dir == UP) begin
      if (cnt >= period_a) begin
        dir_nxt = DOWN;
        cnt_nxt = period_a - W'(1);
      end else begin
        cnt_nxt = cnt + W'(1);
      end
    end else begin
      cnt_nxt = cnt - W'(1);
    end
  end

  always_comb begin
    cmp = '0;
    for (int i = 0; i < N; i++)
      cmp[i] = (cnt < duty_a[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_a   <= 1'b0;
      period_a <= '0;
      for (int i = 0; i < N; i++)
        duty_a[i] <= '0;
    end else if (do_xfer) begin
      mode_a   <= mode_in;
      period_a <= period_in;
      for (int i = 0; i < N; i++)
        duty_a[i] <= duty_in[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      dir         <= UP;
      pwm_out     <= '0;
      period_evt  <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      if (enable)
        pwm_out <= cmp;
      if (load) begin
        cnt         <= mode_in ? '0 : period_in;
        dir         <= UP;
        period_evt  <= 1'b0;
        upd_pending <= 1'b0;
      end else if (enable) begin
        cnt         <= cnt_nxt;
        dir         <= dir_nxt;
        period_evt  <= boundary;
        upd_pending <= xfer ? 1'b0 : (upd_pending | update);
      end else begin
        period_evt  <= 1'b0;
        upd_pending <= upd_pending | update;
      end
    end
  end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Bench for pwm_timer_multi: a phase-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pwm_timer_multi;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           enable = 1'b0;
  logic           load = 1'b0;
  logic           update = 1'b0;
  logic           mode_in = 1'b0;
  logic [W-1:0]   period_in = '0;
  logic [N*W-1:0] duty_in = '0;
  logic [W-1:0]   cnt;
  logic [N-1:0]   pwm_out;
  logic           period_evt;
  logic           upd_pending;

  pwm_timer_multi #(.W(W), .N(N)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .update(update),
    .mode_in(mode_in), .period_in(period_in), .duty_in(duty_in),
    .cnt(cnt), .pwm_out(pwm_out), .period_evt(period_evt), .upd_pending(upd_pending)
  );

  initial forever #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
  endtask

  // Model: counter position is a pure function of the phase m_t since the last transfer.
  int           m_mode = 0, m_per = 0, m_t = 0;
  int           m_duty[N] = '{default: 0};
  bit           m_pend = 0, m_evt = 0;
  logic [N-1:0] m_pwm = '0;

  function automatic int mcnt();
    int q;
    if (m_per == 0) return 0;
    if (m_mode == 0) return m_per - (m_t % (m_per + 1));
    q = m_t % (2 * m_per);
    return (q <= m_per) ? q : 2 * m_per - q;
  endfunction

  function automatic bit mbnd();
    if (m_per == 0) return 1'b1;
    if (m_mode == 0) return (m_t % (m_per + 1)) == m_per;
    return ((m_t % (2 * m_per)) == 0) && (m_t != 0);
  endfunction

  task automatic mxfer();
    m_mode = int'(mode_in);
    m_per  = int'(period_in);
    for (int i = 0; i < N; i++) m_duty[i] = int'(duty_in[i*W +: W]);
  endtask

  always @(posedge clk or negedge reset_n) begin
    int c;
    bit b;
    if (!reset_n) begin
      m_mode = 0; m_per = 0; m_t = 0; m_pend = 0; m_evt = 0; m_pwm = '0;
      for (int i = 0; i < N; i++) m_duty[i] = 0;
    end else begin
      c = mcnt();
      b = mbnd();
      if (enable)
        for (int i = 0; i < N; i++) m_pwm[i] = (c < m_duty[i]);
      if (load) begin
        mxfer(); m_t = 0; m_pend = 0; m_evt = 0;
      end else if (enable) begin
        m_evt = b;
        if (b && (m_pend || update)) begin
          mxfer(); m_t = (m_mode == 1) ? 1 : 0; m_pend = 0;
        end else begin
          m_t++; m_pend = m_pend | update;
        end
      end else begin
        m_evt = 0; m_pend = m_pend | update;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_cnt", int'(cnt), mcnt());
    chk("model_pwm", int'(pwm_out), int'(m_pwm));
    chk("model_evt", int'(period_evt), int'(m_evt));
    chk("model_pend", int'(upd_pending), int'(m_pend));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    for (int k = 0; k < 100; k++) begin
      if (int'(cnt) == v) break;
      @(negedge clk);
    end
    chk("wait_cnt", int'(cnt), v);
  endtask

  initial begin
    int h0, h1, h2, h3, ev;
    int cseq[10];
    cseq = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

    #1 reset_n = 1'b0;
    tick(3);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_pend", int'(upd_pending), 0);
    reset_n = 1'b1;
    tick(2);

    // Edge mode, period 9, duties ch0=3 ch1=0 ch2=10 ch3=5
    enable = 1'b1; load = 1'b1; mode_in = 1'b0; period_in = 16'd9;
    duty_in = {16'd5, 16'd10, 16'd0, 16'd3};
    tick(1);
    load = 1'b0;
    chk("edge_load_cnt", int'(cnt), 9);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; ev = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]); h3 += int'(pwm_out[3]);
      ev += int'(period_evt);
    end
    chk("edge_ch0_high", h0, 6);
    chk("edge_ch1_high", h1, 0);
    chk("edge_ch2_high", h2, 20);
    chk("edge_ch3_high", h3, 10);
    chk("edge_evt_count", ev, 2);

    // Shadow update mid-period
    wait_cnt(6);
    period_in = 16'd4; update = 1'b1;
    tick(1);
    update = 1'b0;
    chk("upd_pend_set", int'(upd_pending), 1);
    wait_cnt(0);
    chk("upd_pend_at_zero", int'(upd_pending), 1);
    tick(1);
    chk("upd_new_cnt", int'(cnt), 4);
    chk("upd_pend_clr", int'(upd_pending), 0);
    chk("upd_evt", int'(period_evt), 1);
    ev = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      ev += int'(period_evt);
    end
    chk("upd_evt_count", ev, 2);

    // update exactly on a boundary cycle
    wait_cnt(0);
    period_in = 16'd7; update = 1'b1;
    tick(1);
    update = 1'b0;
    chk("bnd_upd_cnt", int'(cnt), 7);
    chk("bnd_upd_pend", int'(upd_pending), 0);

    // load + update together, into center mode period 4, duty 2
    load = 1'b1; update = 1'b1; mode_in = 1'b1; period_in = 16'd4;
    duty_in = {16'd2, 16'd2, 16'd2, 16'd2};
    tick(1);
    load = 1'b0; update = 1'b0;
    chk("ld_upd_pend", int'(upd_pending), 0);
    h0 = 0;
    for (int k = 0; k < 10; k++) begin
      chk("center_seq", int'(cnt), cseq[k]);
      if (k >= 1 && k <= 8) h0 += int'(pwm_out[0]);
      if (k == 8) chk("center_evt_valley", int'(period_evt), 0);
      if (k == 9) chk("center_evt_after", int'(period_evt), 1);
      if (k < 9) tick(1);
    end
    chk("center_ch0_high", h0, 3);

    // Freeze while counting down; update request still latches
    wait_cnt(4);
    tick(1);
    enable = 1'b0; update = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      update = 1'b0;
      chk("hold_cnt", int'(cnt), 3);
      chk("hold_pwm", int'(pwm_out), 0);
      chk("hold_evt", int'(period_evt), 0);
    end
    chk("hold_pend", int'(upd_pending), 1);
    enable = 1'b1;
    tick(1);
    chk("resume_down", int'(cnt), 2);

    // Asynchronous reset mid-count
    load = 1'b1; mode_in = 1'b0; period_in = 16'd9;
    duty_in = {16'd5, 16'd10, 16'd0, 16'd3};
    tick(1);
    load = 1'b0; update = 1'b1;
    tick(1);
    update = 1'b0;
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_pend", int'(upd_pending), 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("idle_cnt", int'(cnt), 0);
    chk("idle_evt", int'(period_evt), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
